// File: rtl/mem_stage.sv
// Memory-access stage: services word LW/SW over a req/ack bus, passes all other ops to mem_wb.
// Latency: non-memory ops 0 cycles; memory ops IDLE + N BUSY cycles + DONE (N = ack delay + 1, max MAX_WAIT).
// Backpressure: stallreq_o holds the upstream pipeline while an access is in IDLE/BUSY; bubbles never write back.
//
// Ports: clk/rst (sync, active-high); ex_mem inputs memop_i, mem_addr_i, mem_sdata_i, waddr_i, we_i, wdata_i;
//        data bus mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o <-> mem_ack_i/mem_rdata_i;
//        stallreq_o to hazard control; waddr_o/we_o/wdata_o to mem_wb; bus_err_o one-cycle error pulse.
module mem_stage #(
    parameter int DW       = 32,
    parameter int RW       = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    memop_i,
    input  logic [DW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_sdata_i,
    input  logic [RW-1:0] waddr_i,
    input  logic          we_i,
    input  logic [DW-1:0] wdata_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          stallreq_o,
    output logic [RW-1:0] waddr_o,
    output logic          we_o,
    output logic [DW-1:0] wdata_o,
    output logic          bus_err_o
);

    // Counter only needs to reach MAX_WAIT-1; keep at least one bit for MAX_WAIT == 1.
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   rdata_q, rdata_nxt;
    logic            err_q, err_nxt;

    logic            is_lw, is_sw, is_mem, aligned;

    assign is_lw   = (memop_i == 2'b01);
    assign is_sw   = (memop_i == 2'b10);
    assign is_mem  = is_lw | is_sw;
    assign aligned = (mem_addr_i[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rdata_nxt   = rdata_q;
        err_nxt     = err_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        stallreq_o  = 1'b0;
        waddr_o     = waddr_i;
        we_o        = we_i;
        wdata_o     = wdata_i;
        bus_err_o   = 1'b0;

        case (state)
            IDLE: begin
                if (is_mem) begin
                    stallreq_o = 1'b1;
                    we_o       = 1'b0;
                    if (aligned) begin
                        state_nxt = BUSY;
                        cnt_nxt   = '0;
                    end else begin
                        // Misaligned: skip the bus entirely and report the error in DONE.
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                        rdata_nxt = '0;
                    end
                end
            end

            BUSY: begin
                mem_req_o   = 1'b1;
                stallreq_o  = 1'b1;
                we_o        = 1'b0;
                mem_addr_o  = mem_addr_i;
                mem_we_o    = is_sw;
                mem_wdata_o = is_sw ? mem_sdata_i : '0;
                // Ack takes priority over a coincident timeout.
                if (mem_ack_i) begin
                    rdata_nxt = mem_rdata_i;
                    err_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            DONE: begin
                // Pipeline advances at the end of this cycle; the held op is retired here.
                state_nxt = IDLE;
                bus_err_o = err_q;
                if (is_lw) begin
                    we_o    = we_i & ~err_q;
                    wdata_o = rdata_q;
                end else if (is_sw) begin
                    we_o = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Reset forces every output low immediately, abandoning any access in flight.
        if (rst) begin
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_wdata_o = '0;
            stallreq_o  = 1'b0;
            waddr_o     = '0;
            we_o        = 1'b0;
            wdata_o     = '0;
            bus_err_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed ops with a scoreboard checked on each retire (stallreq_o low).
// Latency: checks stall/req cycle counts per op against hand-computed values.
// Backpressure: stimulus holds each op until the DUT drops stallreq_o.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  memop_i;
    logic [31:0] mem_addr_i, mem_sdata_i, wdata_i;
    logic [4:0]  waddr_i;
    logic        we_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stallreq_o;
    logic [4:0]  waddr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic        bus_err_o;

    mem_stage #(.DW(32), .RW(5), .MAX_WAIT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .memop_i     (memop_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sdata_i (mem_sdata_i),
        .waddr_i     (waddr_i),
        .we_i        (we_i),
        .wdata_i     (wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stallreq_o  (stallreq_o),
        .waddr_o     (waddr_o),
        .we_o        (we_o),
        .wdata_o     (wdata_o),
        .bus_err_o   (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        bit          chk_wdata;
        logic        err;
        int          req_n;
        int          stall_n;
        logic        bwe;
        logic [31:0] baddr;
        logic [31:0] bwdata;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [4:0] wa, input logic w,
                                input logic [31:0] wd, input bit cw, input logic err,
                                input int rn, input int sn, input logic bwe,
                                input logic [31:0] ba, input logic [31:0] bwd);
        exp_t e;
        e.name = name; e.waddr = wa; e.we = w; e.wdata = wd; e.chk_wdata = cw; e.err = err;
        e.req_n = rn; e.stall_n = sn; e.bwe = bwe; e.baddr = ba; e.bwdata = bwd;
        return e;
    endfunction

    // Monitor: accumulate stall/req cycles; on each retire cycle pop and compare.
    int          m_req_n = 0, m_stall_n = 0;
    logic        m_bwe = 1'b0;
    logic [31:0] m_baddr = '0, m_bwdata = '0;

    always @(negedge clk) begin
        if (rst) begin
            m_req_n = 0; m_stall_n = 0; m_bwe = 1'b0; m_baddr = '0; m_bwdata = '0;
        end else begin
            if (mem_req_o) begin
                m_req_n++;
                m_bwe = mem_we_o; m_baddr = mem_addr_o; m_bwdata = mem_wdata_o;
            end
            if (stallreq_o) begin
                m_stall_n++;
            end else if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_waddr"}, 64'(waddr_o), 64'(e.waddr));
                chk({e.name, "_we"}, 64'(we_o), 64'(e.we));
                if (e.chk_wdata) chk({e.name, "_wdata"}, 64'(wdata_o), 64'(e.wdata));
                chk({e.name, "_err"}, 64'(bus_err_o), 64'(e.err));
                chk({e.name, "_req_cycles"}, 64'(m_req_n), 64'(e.req_n));
                chk({e.name, "_stall_cycles"}, 64'(m_stall_n), 64'(e.stall_n));
                chk({e.name, "_bus_we"}, 64'(m_bwe), 64'(e.bwe));
                chk({e.name, "_bus_addr"}, 64'(m_baddr), 64'(e.baddr));
                chk({e.name, "_bus_wdata"}, 64'(m_bwdata), 64'(e.bwdata));
                m_req_n = 0; m_stall_n = 0; m_bwe = 1'b0; m_baddr = '0; m_bwdata = '0;
            end
        end
    end

    // Drive one op and hold it until retire. ack_dly: ack in BUSY cycle ack_dly+1, -1 = never.
    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wa, input logic w, input logic [31:0] wd,
                         input int ack_dly, input logic [31:0] rd, input logic idle_ack,
                         input exp_t e);
        int  busy_n;
        bit  done;
        @(posedge clk); #1;
        sb.push_back(e);
        memop_i = op; mem_addr_i = addr; mem_sdata_i = sdata;
        waddr_i = wa; we_i = w; wdata_i = wd;
        mem_ack_i = idle_ack; mem_rdata_i = idle_ack ? 32'hFFFF_FFFF : 32'h0;
        busy_n = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (mem_req_o) begin
                busy_n++;
                if (ack_dly >= 0 && busy_n == ack_dly + 1) begin
                    mem_ack_i = 1'b1; mem_rdata_i = rd;
                end
            end
            if (!stallreq_o) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                mem_ack_i = 1'b0; mem_rdata_i = '0;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s_retire_timeout: stallreq_o still 1 after 100 cycles, required 0", e.name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; memop_i = 2'b01; mem_addr_i = 32'h100; mem_sdata_i = 32'h5;
        waddr_i = 5'd3; we_i = 1'b1; wdata_i = 32'h77; mem_ack_i = 1'b0; mem_rdata_i = '0;

        // Reset gating: every output 0 while rst is high, even with an LW pending.
        @(negedge clk);
        chk("rst_req", 64'(mem_req_o), 0);
        chk("rst_bus_we", 64'(mem_we_o), 0);
        chk("rst_bus_addr", 64'(mem_addr_o), 0);
        chk("rst_bus_wdata", 64'(mem_wdata_o), 0);
        chk("rst_stall", 64'(stallreq_o), 0);
        chk("rst_waddr", 64'(waddr_o), 0);
        chk("rst_we", 64'(we_o), 0);
        chk("rst_wdata", 64'(wdata_o), 0);
        chk("rst_err", 64'(bus_err_o), 0);
        @(posedge clk); #1;
        rst = 1'b0; memop_i = 2'b00;

        // Pass-through
        issue(2'b00, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_00F0, -1, 32'h0, 1'b0,
              mk("pass", 5'd3, 1'b1, 32'h0000_00F0, 1, 0, 0, 0, 0, 32'h0, 32'h0));
        // LW, ack in first BUSY cycle
        issue(2'b01, 32'h100, 32'h0, 5'd7, 1'b1, 32'h55, 0, 32'hDEAD_BEEF, 1'b0,
              mk("lw0", 5'd7, 1'b1, 32'hDEAD_BEEF, 1, 0, 1, 2, 0, 32'h100, 32'h0));
        // SW, ack three cycles late; we_i=1 must be suppressed
        issue(2'b10, 32'h20, 32'h1234_5678, 5'd9, 1'b1, 32'h20, 3, 32'h0, 1'b0,
              mk("sw3", 5'd9, 1'b0, 32'h20, 1, 0, 4, 5, 1, 32'h20, 32'h1234_5678));
        // LW timeout: 15 req cycles, error, no write
        issue(2'b01, 32'h200, 32'h0, 5'd5, 1'b1, 32'h66, -1, 32'h0, 1'b0,
              mk("lw_to", 5'd5, 1'b0, 32'h0, 1, 1, 15, 16, 0, 32'h200, 32'h0));
        // Late ack while idle is ignored; error pulse has ended
        issue(2'b00, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0000_ABCD, -1, 32'h0, 1'b1,
              mk("late_ack", 5'd4, 1'b1, 32'h0000_ABCD, 1, 0, 0, 0, 0, 32'h0, 32'h0));
        // Misaligned LW: no bus request, one stall cycle, error
        issue(2'b01, 32'h102, 32'h0, 5'd6, 1'b1, 32'h11, -1, 32'h0, 1'b0,
              mk("misalign", 5'd6, 1'b0, 32'h0, 0, 1, 0, 1, 0, 32'h0, 32'h0));
        // Back-to-back: LW with one wait, then SW (memop 11 aside, op code 11 acts as none)
        issue(2'b01, 32'h104, 32'h0, 5'd8, 1'b1, 32'h22, 1, 32'hCAFE_F00D, 1'b0,
              mk("b2b_lw", 5'd8, 1'b1, 32'hCAFE_F00D, 1, 0, 2, 3, 0, 32'h104, 32'h0));
        issue(2'b10, 32'h108, 32'hA5A5_5A5A, 5'd10, 1'b0, 32'h108, 0, 32'h0, 1'b0,
              mk("b2b_sw", 5'd10, 1'b0, 32'h108, 1, 0, 1, 2, 1, 32'h108, 32'hA5A5_5A5A));
        issue(2'b11, 32'h10C, 32'h0, 5'd11, 1'b1, 32'h0000_3333, -1, 32'h0, 1'b0,
              mk("op11", 5'd11, 1'b1, 32'h0000_3333, 1, 0, 0, 0, 0, 32'h0, 32'h0));

        // Reset in the second BUSY cycle
        @(posedge clk); #1;
        memop_i = 2'b01; mem_addr_i = 32'h300; waddr_i = 5'd12; we_i = 1'b1; wdata_i = 32'h0;
        @(posedge clk); #1;          // now BUSY (first cycle)
        @(negedge clk);
        chk("rstmid_req_before", 64'(mem_req_o), 1);
        @(posedge clk); #1;          // second BUSY cycle
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_req", 64'(mem_req_o), 0);
        chk("rstmid_stall", 64'(stallreq_o), 0);
        chk("rstmid_we", 64'(we_o), 0);
        @(posedge clk); #1;
        rst = 1'b0; memop_i = 2'b00; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_0BAD;
        @(negedge clk);
        chk("rstmid_ack_req", 64'(mem_req_o), 0);
        chk("rstmid_ack_err", 64'(bus_err_o), 0);
        issue(2'b00, 32'h0, 32'h0, 5'd13, 1'b0, 32'h0000_0042, -1, 32'h0, 1'b1,
              mk("post_rst_pass", 5'd13, 1'b0, 32'h0000_0042, 1, 0, 0, 0, 0, 32'h0, 32'h0));
        issue(2'b01, 32'h400, 32'h0, 5'd2, 1'b1, 32'h0, 0, 32'h0BAD_CAFE, 1'b0,
              mk("post_rst_lw", 5'd2, 1'b1, 32'h0BAD_CAFE, 1, 0, 1, 2, 0, 32'h400, 32'h0));

        @(posedge clk); #1;
        memop_i = 2'b00; mem_ack_i = 1'b0;
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the ex_mem register that captures the execute stage's result. It services word loads and stores over a simple req/ack data bus using a small state machine, and stalls the pipeline while an access is outstanding. All other instructions pass through to mem_wb unchanged. It also returns a timeout or misalignment error flag.

## Interface
Parameters:
- DW, 32, data / address width (matches `REG_BUS`)
- RW, 5, register-address width (matches `REG_ADDR_BUS`)
- MAX_WAIT, 15, maximum BUSY cycles without ack before timeout (>=1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous reset, active-high (`RST_ENABLE`)
- memop_i  in  2  00 none, 01 LW, 10 SW, 11 treated as none
- mem_addr_i  in  DW  effective address from ex_mem
- mem_sdata_i  in  DW  store data from ex_mem
- waddr_i  in  RW  destination register from ex_mem
- we_i  in  1  register write enable from ex_mem
- wdata_i  in  DW  execute result from ex_mem
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write strobe (SW)
- mem_addr_o  out  DW  bus address
- mem_wdata_o  out  DW  bus write data
- mem_ack_i  in  1  bus completion, single-cycle pulse
- mem_rdata_i  in  DW  read data, valid with mem_ack_i
- stallreq_o  out  1  hold PC/if_id/id_ex/ex_mem, bubble into mem_wb
- waddr_o  out  RW  to mem_wb
- we_o  out  1  to mem_wb
- wdata_o  out  DW  to mem_wb
- bus_err_o  out  1  one-cycle error pulse

## Operation
- State machine states: IDLE, BUSY, DONE. It also holds a wait counter (width for 0..MAX_WAIT-1), an rdata_q register (DW bits) and an err_q flag.
- IDLE, memop none: pass-through. waddr_o=waddr_i, we_o=we_i, wdata_o=wdata_i. stallreq_o=0.
- IDLE, memop LW/SW, mem_addr_i[1:0]==0: stallreq_o=1 (combinational). Next state is BUSY and the counter is cleared.
- IDLE, memop LW/SW, mem_addr_i[1:0]!=0 (misaligned): stallreq_o=1, no bus request. Next state is DONE with err_q=1.
- BUSY: mem_req_o=1 and stallreq_o=1. mem_addr_o=mem_addr_i. mem_we_o=1 only for SW. mem_wdata_o=mem_sdata_i for SW, else 0.
  - On mem_ack_i: rdata_q<=mem_rdata_i, err_q<=0, next state DONE.
  - Without ack, if counter==MAX_WAIT-1: err_q<=1, rdata_q<=0, next state DONE. Otherwise the counter increments.
  - If ack and timeout fall in the same cycle, ack wins.
- DONE: stallreq_o=0, so ex_mem/mem_wb advance at this edge. Next state is IDLE unconditionally, and inputs are ignored for the state decision.
  - bus_err_o=err_q.
  - LW: we_o=we_i & ~err_q, wdata_o=rdata_q. SW: we_o=0, wdata_o=wdata_i.
- While stallreq_o=1: we_o=0, so bubbles never write the register file.
- Bus outputs are 0 outside BUSY. mem_ack_i is ignored outside BUSY.
- Reset: while rst=1 every output is 0 (combinational gating). At the reset edge: state=IDLE, counter=0, rdata_q=0, err_q=0. Reset during BUSY drops mem_req_o in the same cycle, the access is abandoned, and a late ack is ignored.

## Timing
- Non-memory op: 0-cycle combinational pass, no stall.
- Access with ack in the first BUSY cycle: IDLE(stall) -> BUSY(req, ack) -> DONE(result). That is 2 stall cycles, and the result reaches mem_wb at the end of cycle 3.
- Each cycle of ack delay adds one stall cycle.
- Timeout: exactly MAX_WAIT BUSY cycles with req high, then DONE.
- Misaligned access: 1 stall cycle (IDLE), then DONE with bus_err_o=1.
- Back-to-back memory ops: the second op sees IDLE in the cycle after DONE. There is no dead cycle beyond the FSM sequence.

## Test plan
- Reset/pass-through: assert rst with memop=01 -> all outputs 0. Release, memop=00, waddr_i=3, we_i=1, wdata_i=0x0000_00F0 -> same values on the outputs in the same cycle, stallreq_o=0.
- LW zero-wait: memop=01, addr=0x100, we_i=1, waddr_i=7, ack with rdata=0xDEAD_BEEF in the first BUSY cycle -> stallreq_o high for 2 cycles, mem_req_o for 1 cycle, then DONE with we_o=1, waddr_o=7, wdata_o=0xDEAD_BEEF, bus_err_o=0.
- SW with 3-cycle ack delay: memop=10, addr=0x20, sdata=0x1234_5678 -> mem_req_o=mem_we_o=1 for 4 cycles, mem_wdata_o=0x1234_5678, then DONE with we_o=0 and 5 stall cycles in total.
- Timeout (MAX_WAIT=15): LW with no ack -> mem_req_o high for exactly 15 cycles, then DONE with bus_err_o=1 for one cycle, we_o=0. An ack arriving afterwards is ignored.
- Misaligned: LW at addr 0x102 -> no mem_req_o, 1 stall cycle, then bus_err_o=1, we_o=0.
- Reset mid-BUSY: rst=1 in the second BUSY cycle -> mem_req_o=0 that cycle and state IDLE. An ack in the following cycle has no effect, and the next LW completes normally.
